// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data requester ports and backing-memory port of the arbiter
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        freeze;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready,
    output mem_en, mem_we, mem_addr, mem_wdata, freeze
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata, freeze
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) arbiter onto a fixed-latency memory
// One access per LATENCY+2 cycles; ties alternate between requesters.
module mem_arbiter #(
  parameter int unsigned LATENCY = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);
  localparam logic       GNT_IF   = 1'b0;
  localparam logic       GNT_DM   = 1'b1;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        pick_dm;
  logic        if_rdy, dm_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= GNT_IF;
      last_grant_q <= GNT_IF;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    // On a tie the data side wins unless it was the one served last.
    pick_dm      = bus.dm_req & (~bus.if_req | (last_grant_q == GNT_IF));
    case (state_q)
      IDLE: begin
        if (bus.if_req | bus.dm_req) begin
          state_d = BUSY;
          cnt_d   = '0;
          grant_d = pick_dm;
          we_d    = pick_dm & bus.dm_we;
          addr_d  = pick_dm ? bus.dm_addr : bus.if_addr;
          if (pick_dm) begin
            wdata_d = bus.dm_wdata;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          state_d      = RESP;
          last_grant_d = grant_q;
          if (grant_q == GNT_IF) begin
            if_rdata_d = bus.mem_rdata;
          end else if (!we_q) begin
            dm_rdata_d = bus.mem_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    if_rdy        = (state_q == RESP) && (grant_q == GNT_IF);
    dm_rdy        = (state_q == RESP) && (grant_q == GNT_DM);
    bus.if_ready  = if_rdy;
    bus.dm_ready  = dm_rdy;
    bus.if_rdata  = if_rdata_q;
    bus.dm_rdata  = dm_rdata_q;
    bus.mem_en    = (state_q == BUSY);
    bus.mem_we    = (state_q == BUSY) && we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.freeze    = (bus.if_req & ~if_rdy) | (bus.dm_req & ~dm_rdy);
  end

endmodule
